if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the ROM address.
- Captures the returned instruction word into the IF/ID pipeline register; honours decode stalls and execute-stage redirects (branch/jump).
- Halts cleanly on fetching an unprogrammed ROM word (32'hFFFF_FFFF) or on a misaligned redirect target.

---
 rtl/if_stage.sv | 106 ++++++++++
 tb/tb_if_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and fills IF/ID.
// Stops permanently (until reset) on an unprogrammed ROM word or a misaligned redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] UNPROG_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      if_id_instr_o,
    output logic [31:0]      if_id_pc4_o,
    output logic             if_id_valid_o,
    output logic             halted_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic [31:0]        r_pc4;
    logic               r_valid;
    logic               r_halted;
    logic               r_misalign;
    logic [CNT_W-1:0]   r_cnt;

    logic [31:0]        w_pc4;
    logic               w_redirAligned;

    assign w_pc4          = r_pc + 32'd4;
    assign w_redirAligned = (redirect_pc_i[1:0] == 2'b00);

    // A redirect always wins because whatever the ROM returns this cycle is wrong-path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_pc4      <= 32'h0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (redirect_i) begin
                        r_instr <= 32'h0;
                        r_pc4   <= 32'h0;
                        r_valid <= 1'b0;
                        if (w_redirAligned) begin
                            r_pc <= redirect_pc_i;
                        end else begin
                            r_misalign <= 1'b1;
                            r_halted   <= 1'b1;
                            r_state    <= HALT;
                        end
                    end else if (stall_i) begin
                        r_pc <= r_pc;
                    end else if (imem_data_i == UNPROG_WORD) begin
                        r_instr  <= 32'h0;
                        r_pc4    <= 32'h0;
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= HALT;
                    end else begin
                        r_pc    <= w_pc4;
                        r_instr <= imem_data_i;
                        r_pc4   <= w_pc4;
                        r_valid <= 1'b1;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                HALT: begin
                    // Keep feeding bubbles so downstream stages drain cleanly.
                    r_instr  <= 32'h0;
                    r_pc4    <= 32'h0;
                    r_valid  <= 1'b0;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

    assign imem_addr_o   = r_pc;
    assign if_id_instr_o = r_instr;
    assign if_id_pc4_o   = r_pc4;
    assign if_id_valid_o = r_valid;
    assign halted_o      = r_halted;
    assign misalign_o    = r_misalign;
    assign fetch_cnt_o   = r_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then random
// stall/redirect/reset traffic checked every cycle against a behavioural model.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic        misalign;
    logic [15:0] fetchCnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] rom [17];

    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mPc4;
    logic        mValid;
    logic        mHalted;
    logic        mMisalign;
    logic [15:0] mCnt;

    if_stage #(
        .RESET_PC    (32'h0000_0000),
        .UNPROG_WORD (32'hFFFF_FFFF),
        .CNT_W       (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (tgt),
        .imem_addr_o   (imemAddr),
        .imem_data_i   (imemData),
        .if_id_instr_o (instr),
        .if_id_pc4_o   (pc4),
        .if_id_valid_o (valid),
        .halted_o      (halted),
        .misalign_o    (misalign),
        .fetch_cnt_o   (fetchCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Programmed words live at 0x00-0x40 plus the top word, so PC wrap can be exercised.
    function automatic logic [31:0] romRead(input logic [31:0] addr);
        if (addr == 32'hFFFF_FFFC) return 32'h2010_0001;
        if (addr < 32'h44 && addr[1:0] == 2'b00) return rom[addr[6:2]];
        return 32'hFFFF_FFFF;
    endfunction

    assign imemData = romRead(imemAddr);

    // Reference model: the fetch rules applied once per rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPc <= 32'h0; mInstr <= 32'h0; mPc4 <= 32'h0; mValid <= 1'b0;
            mHalted <= 1'b0; mMisalign <= 1'b0; mCnt <= 16'h0;
        end else if (mHalted) begin
            mInstr <= 32'h0; mPc4 <= 32'h0; mValid <= 1'b0;
        end else if (redir) begin
            mInstr <= 32'h0; mPc4 <= 32'h0; mValid <= 1'b0;
            if (tgt % 4 == 0) mPc <= tgt;
            else begin
                mMisalign <= 1'b1;
                mHalted   <= 1'b1;
            end
        end else if (!stall) begin
            if (romRead(mPc) == 32'hFFFF_FFFF) begin
                mInstr <= 32'h0; mPc4 <= 32'h0; mValid <= 1'b0; mHalted <= 1'b1;
            end else begin
                mInstr <= romRead(mPc);
                mPc4   <= mPc + 32'd4;
                mValid <= 1'b1;
                mCnt   <= mCnt + 16'd1;
                mPc    <= mPc + 32'd4;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("addr",     imemAddr,            mPc);
        checkOutput("instr",    instr,               mInstr);
        checkOutput("pc4",      pc4,                 mPc4);
        checkOutput("valid",    {31'h0, valid},      {31'h0, mValid});
        checkOutput("halted",   {31'h0, halted},     {31'h0, mHalted});
        checkOutput("misalign", {31'h0, misalign},   {31'h0, mMisalign});
        checkOutput("fetchCnt", {16'h0, fetchCnt},   {16'h0, mCnt});
    end

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] t);
        stall = s;
        redir = r;
        tgt   = t;
        @(posedge clk);
        #1;
        stall = 1'b0;
        redir = 1'b0;
    endtask

    task automatic runSteps(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    endtask

    // Asserts reset between edges, checks the immediate clear, holds it over one edge.
    task automatic pulseReset();
        #2 rst = 1'b1;
        #1;
        checkOutput("rstAddr",   imemAddr, 32'h0);
        checkOutput("rstValid",  {31'h0, valid}, 32'h0);
        checkOutput("rstHalted", {31'h0, halted}, 32'h0);
        checkOutput("rstMis",    {31'h0, misalign}, 32'h0);
        checkOutput("rstCnt",    {16'h0, fetchCnt}, 32'h0);
        checkOutput("rstInstr",  instr, 32'h0);
        @(posedge clk);
        #2;
        stall = 1'b0;
        redir = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rom[0]  = 32'h2008_0005; rom[1]  = 32'h2009_000A; rom[2]  = 32'h3C08_0010;
        rom[3]  = 32'h0109_5020; rom[4]  = 32'h0000_0000; rom[5]  = 32'hAC0A_0004;
        rom[6]  = 32'h8C0B_0004; rom[7]  = 32'h0128_5020; rom[8]  = 32'h1109_0002;
        rom[9]  = 32'h2129_0001; rom[10] = 32'h0800_0002; rom[11] = 32'h0000_0000;
        rom[12] = 32'h3C0C_1234; rom[13] = 32'h358C_5678; rom[14] = 32'h018C_6820;
        rom[15] = 32'hAC0D_0008; rom[16] = 32'h0000_000C;
        rst = 1'b1; stall = 1'b0; redir = 1'b0; tgt = 32'h0;
        #12 rst = 1'b0;

        // Free run into the unprogrammed word at 0x44.
        runSteps(1);
        checkOutput("e1Instr", instr, 32'h2008_0005);
        checkOutput("e1Pc4",   pc4,   32'h4);
        runSteps(2);
        checkOutput("e3Instr", instr, 32'h3C08_0010);
        checkOutput("e3Pc4",   pc4,   32'hC);
        runSteps(2);
        checkOutput("nopInstr", instr, 32'h0);
        checkOutput("nopValid", {31'h0, valid}, 32'h1);
        checkOutput("nopCnt",   {16'h0, fetchCnt}, 32'd5);
        runSteps(12);
        checkOutput("e17Addr", imemAddr, 32'h44);
        checkOutput("e17Cnt",  {16'h0, fetchCnt}, 32'd17);
        runSteps(1);
        checkOutput("haltFlag",  {31'h0, halted}, 32'h1);
        checkOutput("haltValid", {31'h0, valid}, 32'h0);
        checkOutput("haltCnt",   {16'h0, fetchCnt}, 32'd17);
        checkOutput("haltAddr",  imemAddr, 32'h44);

        // Reset out of HALT, then stall at 0x1C.
        pulseReset();
        runSteps(7);
        checkOutput("preStallAddr", imemAddr, 32'h1C);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("stallAddr",  imemAddr, 32'h1C);
        checkOutput("stallCnt",   {16'h0, fetchCnt}, 32'd7);
        checkOutput("stallInstr", instr, 32'h8C0B_0004);
        runSteps(1);
        checkOutput("relInstr", instr, 32'h0128_5020);
        checkOutput("relPc4",   pc4,   32'h20);

        // Redirect beats a simultaneous stall.
        runSteps(5);
        checkOutput("at34", imemAddr, 32'h34);
        applyStimulus(1'b1, 1'b1, 32'h08);
        checkOutput("redirAddr",  imemAddr, 32'h08);
        checkOutput("redirValid", {31'h0, valid}, 32'h0);
        runSteps(1);
        checkOutput("postRedir", instr, 32'h3C08_0010);

        // Misaligned redirect halts; later redirects are ignored.
        applyStimulus(1'b0, 1'b1, 32'h22);
        checkOutput("misFlag",  {31'h0, misalign}, 32'h1);
        checkOutput("misHalt",  {31'h0, halted}, 32'h1);
        checkOutput("misAddr",  imemAddr, 32'h0C);
        applyStimulus(1'b0, 1'b1, 32'h00);
        checkOutput("ignRedir", imemAddr, 32'h0C);

        // Reset in the middle of a stall.
        pulseReset();
        runSteps(3);
        stall = 1'b1;
        @(posedge clk);
        #1;
        pulseReset();
        runSteps(1);
        checkOutput("resume", instr, 32'h2008_0005);

        // Redirect coinciding with the unprogrammed fetch at 0x44.
        runSteps(16);
        checkOutput("at44", imemAddr, 32'h44);
        applyStimulus(1'b0, 1'b1, 32'h1C);
        checkOutput("noHalt", {31'h0, halted}, 32'h0);
        checkOutput("to1C",   imemAddr, 32'h1C);

        // PC wrap from the top word.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        runSteps(1);
        checkOutput("wrapInstr", instr, 32'h2010_0001);
        checkOutput("wrapPc4",   pc4,   32'h0);
        checkOutput("wrapAddr",  imemAddr, 32'h0);

        // Random traffic, each episode bounded in length.
        for (int ep = 0; ep < 40; ep++) begin
            pulseReset();
            for (int s = 0; s < 50 && !mHalted; s++) begin
                int r;
                int k;
                logic [31:0] t;
                r = $urandom_range(0, 99);
                k = $urandom_range(0, 19);
                if (k < 17)       t = k * 4;
                else if (k == 17) t = 32'hFFFF_FFFC;
                else if (k == 18) t = {$urandom_range(0, 127), 2'b00} | 32'($urandom_range(1, 3));
                else              t = 32'h44;
                if (r < 2)        pulseReset();
                else if (r < 14)  applyStimulus($urandom_range(0, 1) == 1, 1'b1, t);
                else if (r < 40)  applyStimulus(1'b1, 1'b0, t);
                else              applyStimulus(1'b0, 1'b0, t);
            end
            runSteps(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
